// File: rtl/nasti_lite_initiator_if.sv
// rtl/nasti_lite_initiator_if.sv - NASTI-Lite channel interfaces used by nasti_lite_initiator
//
// nasti_lite_req_if: initiator-driven channel (AW, W, AR).
//   valid/id/addr/prot/data/strb flow master -> slave, ready flows slave -> master.
// nasti_lite_rsp_if: target-driven channel (B, R).
//   valid/id/data/resp flow slave -> master, ready flows master -> slave.

interface nasti_lite_req_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic                    valid;
  logic                    ready;
  logic [ID_WIDTH-1:0]     id;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [2:0]              prot;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, id, addr, prot, data, strb, input ready);
  modport slave  (input valid, id, addr, prot, data, strb, output ready);
endinterface

interface nasti_lite_rsp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            resp;

  modport master (input valid, id, data, resp, output ready);
  modport slave  (output valid, id, data, resp, input ready);
endinterface

// File: rtl/nasti_lite_initiator.sv
// rtl/nasti_lite_initiator.sv - single-outstanding NASTI-Lite initiator with response timeout
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_write/addr/wdata/wstrb    request payload, latched on acceptance
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err             read data (0 on writes/timeouts), status
//                                 (0 OKAY, 1 timeout, 2 SLVERR, 3 DECERR)
//   nasti_aw/w/ar                 address and write-data channels (master side)
//   nasti_b/r                     write-response and read-data channels (master side)
//   stale_cnt                     saturating count of discarded b/r beats

module nasti_lite_initiator #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  nasti_lite_req_if.master        nasti_aw,
  nasti_lite_req_if.master        nasti_w,
  nasti_lite_rsp_if.master        nasti_b,
  nasti_lite_req_if.master        nasti_ar,
  nasti_lite_rsp_if.master        nasti_r,
  output logic [7:0]              stale_cnt
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;

  // Timer value in the last permitted wait cycle; leaving on it gives exactly
  // TIMEOUT cycles in WRESP/RDATA.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     next_tag_q;
  logic [ID_WIDTH-1:0]     cur_id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_done_q, w_done_q;
  logic [15:0]             timer_q;

  logic       accept, aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic       b_match, r_match, waiting, timed_out;
  logic [1:0] stale_inc;
  logic [8:0] stale_sum;
  logic       unused_b_data;

  // Write responses carry no data; keep the bus visible to lint only.
  assign unused_b_data = ^nasti_b.data;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  assign nasti_aw.valid = (state_q == WADDR) && !aw_done_q;
  assign nasti_aw.id    = cur_id_q;
  assign nasti_aw.addr  = addr_q;
  assign nasti_aw.prot  = 3'b000;
  assign nasti_aw.data  = '0;
  assign nasti_aw.strb  = '0;

  assign nasti_w.valid  = (state_q == WADDR) && !w_done_q;
  assign nasti_w.id     = cur_id_q;
  assign nasti_w.addr   = '0;
  assign nasti_w.prot   = 3'b000;
  assign nasti_w.data   = wdata_q;
  assign nasti_w.strb   = wstrb_q;

  assign nasti_ar.valid = (state_q == RADDR);
  assign nasti_ar.id    = cur_id_q;
  assign nasti_ar.addr  = addr_q;
  assign nasti_ar.prot  = 3'b000;
  assign nasti_ar.data  = '0;
  assign nasti_ar.strb  = '0;

  // Beats are accepted (and, if unexpected, dropped) everywhere but RESP.
  assign nasti_b.ready  = (state_q != RESP);
  assign nasti_r.ready  = (state_q != RESP);

  always_comb begin
    state_d   = state_q;
    accept    = req_valid && req_ready;
    aw_hs     = nasti_aw.valid && nasti_aw.ready;
    w_hs      = nasti_w.valid && nasti_w.ready;
    ar_hs     = nasti_ar.valid && nasti_ar.ready;
    b_hs      = nasti_b.valid && nasti_b.ready;
    r_hs      = nasti_r.valid && nasti_r.ready;
    b_match   = b_hs && (state_q == WRESP) && (nasti_b.id == cur_id_q);
    r_match   = r_hs && (state_q == RDATA) && (nasti_r.id == cur_id_q);
    waiting   = (state_q == WRESP) || (state_q == RDATA);
    timed_out = waiting && (timer_q == TIMER_LAST);
    stale_inc = {1'b0, b_hs && !b_match} + {1'b0, r_hs && !r_match};
    stale_sum = {1'b0, stale_cnt} + {7'd0, stale_inc};

    case (state_q)
      IDLE:  if (accept) state_d = req_write ? WADDR : RADDR;
      WADDR: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
      WRESP: if (b_match || timed_out) state_d = RESP;
      RADDR: if (ar_hs) state_d = RDATA;
      RDATA: if (r_match || timed_out) state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      next_tag_q <= '0;
      cur_id_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      timer_q    <= '0;
      stale_cnt  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 2'd0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        wstrb_q    <= req_wstrb;
        cur_id_q   <= next_tag_q;
        next_tag_q <= next_tag_q + 1'b1;
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end

      timer_q <= waiting ? timer_q + 16'd1 : 16'd0;

      // A matching beat wins over a timeout landing in the same cycle.
      if (b_match) begin
        rsp_err   <= nasti_b.resp;
        rsp_rdata <= '0;
      end else if (r_match) begin
        rsp_err   <= nasti_r.resp;
        rsp_rdata <= nasti_r.data;
      end else if (timed_out) begin
        rsp_err   <= 2'd1;
        rsp_rdata <= '0;
      end

      stale_cnt <= stale_sum[8] ? 8'hFF : stale_sum[7:0];
    end
  end

endmodule
